spi_reg_slave: RTL

SPI mode-0 responder (CPOL=0, CPHA=0) sitting at the far end of the SPI master's SCLK/MOSI/MISO/SS bus. It fronts a 4 x 8-bit register file. The first byte of each SS-low frame is a command: bit7 = 1 for write, 0 for read; bits[1:0] give the start address. Following bytes write or read consecutive registers with auto-increment. Register contents are exported in parallel to the system side.

---
 rtl/spi_reg_slave_if.sv | 10 +
 rtl/spi_reg_slave.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave_if.sv
// rtl/spi_reg_slave_if.sv - SPI bus signals (SCLK/MOSI/SS/MISO) shared by master and spi_reg_slave
interface spi_reg_slave_if;
  logic SCLK;
  logic MOSI;
  logic SS;
  logic MISO;

  modport master (output SCLK, output MOSI, output SS, input MISO);
  modport slave  (input SCLK, input MOSI, input SS, output MISO);
endinterface

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-0 register slave, 8-bit registers with auto-increment; optional SPI_REG_SLAVE_MISO_TRISTATE_EN
module spi_reg_slave #(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_reg_slave_if.slave        spi,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_pulse,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sclk_d;
  logic                   ss_d;
  logic [SYNC_STAGES:0]   warm;
  logic                   armed;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [6:0]        shin, shin_nx;
  logic [7:0]        miso_sr, miso_sr_nx;
  logic [ADDR_W-1:0] addr, addr_nx, addr_inc;
  logic [7:0]        byte_in;
  logic              byte_done;
  logic              wr_en;

  logic [7:0] regs [NUM_REGS];

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  // A fall only counts once SS has been seen high after reset, so a frame
  // already running when reset released is ignored.
  assign ss_fall   = armed & ss_d & ~ss_s;
  assign ss_rise   = ss_s & ~ss_d;

  assign busy      = ~ss_s;
  assign byte_in   = {shin, mosi_s};
  assign byte_done = sclk_rise & (cnt == 3'd7);
  assign addr_inc  = addr + ADDR_W'(1);

  // Synchronizers, edge-detect flops and the post-reset arming logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
      warm      <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi.SCLK);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi.MOSI);
      ss_sync   <= (ss_sync << 1) | SYNC_STAGES'(spi.SS);
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      if (warm[SYNC_STAGES] && ss_s)
        armed <= 1'b1;
    end
  end

  // FSM state and shift/count/address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      shin    <= '0;
      miso_sr <= '0;
      addr    <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      shin    <= shin_nx;
      miso_sr <= miso_sr_nx;
      addr    <= addr_nx;
    end
  end

  // Next-state logic: SCLK edges are handled first, then an SS release overrides.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    shin_nx    = shin;
    miso_sr_nx = miso_sr;
    addr_nx    = addr;
    wr_en      = 1'b0;

    if (state != IDLE) begin
      if (sclk_rise) begin
        shin_nx = byte_in[6:0];
        cnt_nx  = cnt + 3'd1;
      end
      // The fall right after a reload (cnt back at 0) must keep bit 7 on MISO.
      if (sclk_fall && state == RDATA && cnt != 3'd0)
        miso_sr_nx = {miso_sr[6:0], 1'b0};
    end

    case (state)
      IDLE: begin
        cnt_nx     = 3'd0;
        shin_nx    = '0;
        miso_sr_nx = '0;
        addr_nx    = '0;
        if (ss_fall)
          state_nx = CMD;
      end
      CMD: begin
        if (byte_done) begin
          addr_nx = byte_in[ADDR_W-1:0];
          if (byte_in[7]) begin
            state_nx = WDATA;
          end else begin
            state_nx   = RDATA;
            miso_sr_nx = regs[byte_in[ADDR_W-1:0]];
          end
        end
      end
      WDATA: begin
        if (byte_done) begin
          wr_en   = 1'b1;
          addr_nx = addr_inc;
        end
      end
      RDATA: begin
        if (byte_done) begin
          addr_nx    = addr_inc;
          miso_sr_nx = regs[addr_inc];
        end
      end
      default: state_nx = IDLE;
    endcase

    if (ss_rise && state != IDLE) begin
      state_nx   = IDLE;
      cnt_nx     = 3'd0;
      shin_nx    = '0;
      miso_sr_nx = '0;
      addr_nx    = '0;
    end
  end

  // Register file write port and write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
    end else begin
      wr_pulse <= wr_en;
      if (wr_en) begin
        regs[addr] <= byte_in;
        wr_addr    <= addr;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_o
    assign regs_o[gi*8 +: 8] = regs[gi];
  end

`ifdef SPI_REG_SLAVE_MISO_TRISTATE_EN
  assign spi.MISO = (ss_s || state == IDLE) ? 1'bz
                  : ((state == RDATA) ? miso_sr[7] : 1'b0);
`else
  assign spi.MISO = (state == RDATA) ? miso_sr[7] : 1'b0;
`endif

endmodule
